// File: rtl/mano_seq_core.sv
// mano_seq_core: multi-cycle Mano-style accumulator machine with an
// internal word memory, a step-enabled fetch/decode/execute FSM and a
// side load/inspect port that is usable while the core sits in HALT.
// Optional build macro: MANO_INDIRECT_EN enables I-bit indirection.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   step_en            advance the FSM one state on this edge
//   start              leave HALT and fetch at current PC
//   ld_we/ld_addr/ld_data  memory load port (HALT only)
//   rd_data            mem[ld_addr], combinational
//   acc, e_flag, pc    architectural state
//   state, halted      FSM encoding and HALT indicator
module mano_seq_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic              start,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] acc,
  output logic              e_flag,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_F0   = 3'd0,
    S_F1   = 3'd1,
    S_DEC  = 3'd2,
    S_IND0 = 3'd3,
    S_IND1 = 3'd4,
    S_EX0  = 3'd5,
    S_EX1  = 3'd6,
    S_HALT = 3'd7
  } state_e;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_CLA = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mbr_q, mbr_d;
  // Only the opcode field of IR is ever consulted after DEC.
  logic [2:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic                e_q, e_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   mem_rd;
  logic                adv;
  logic                sta_wr;
  logic                ld_wr;

  assign mem_rd  = mem_q[mar_q];
  assign rd_data = mem_q[ld_addr];
  assign acc     = ac_q;
  assign e_flag  = e_q;
  assign pc      = pc_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);

  assign adv    = step_en && (state_q != S_HALT);
  assign ld_wr  = ld_we && (state_q == S_HALT);
  assign sta_wr = rst_n && adv && (state_q == S_EX0)
               && (ir_q == OP_STA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      pc_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
    end
  end

  // Memory is deliberately not reset; the two write sources are
  // mutually exclusive because one needs HALT and the other EX0.
  always_ff @(posedge clk) begin
    if (ld_wr)
      mem_q[ld_addr] <= ld_data;
    else if (sta_wr)
      mem_q[mar_q] <= ac_q;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_HALT) begin
      if (start) state_d = S_F0;
    end else if (step_en) begin
      unique case (state_q)
        S_F0:   state_d = S_F1;
        S_F1:   state_d = S_DEC;
`ifdef MANO_INDIRECT_EN
        S_DEC:  state_d = mbr_q[DATA_W-1] ? S_IND0 : S_EX0;
`else
        S_DEC:  state_d = S_EX0;
`endif
        S_IND0: state_d = S_IND1;
        S_IND1: state_d = S_EX0;
        S_EX0: begin
          unique case (ir_q)
            OP_LDA, OP_ADD, OP_AND: state_d = S_EX1;
            OP_HLT:                 state_d = S_HALT;
            default:                state_d = S_F0;
          endcase
        end
        S_EX1:  state_d = S_F0;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mbr_d = mbr_q;
    ir_d  = ir_q;
    ac_d  = ac_q;
    e_d   = e_q;
    if (adv) begin
      unique case (state_q)
        S_F0: mar_d = pc_q;
        S_F1: begin
          mbr_d = mem_rd;
          pc_d  = pc_q + ADDR_W'(1);
        end
        S_DEC: begin
          ir_d  = mbr_q[DATA_W-2 -: 3];
          mar_d = mbr_q[ADDR_W-1:0];
        end
        S_IND0: mbr_d = mem_rd;
        S_IND1: mar_d = mbr_q[ADDR_W-1:0];
        S_EX0: begin
          unique case (ir_q)
            OP_LDA, OP_ADD, OP_AND: mbr_d = mem_rd;
            OP_JMP: pc_d = mar_q;
            OP_CLA: ac_d = '0;
            OP_INC: {e_d, ac_d} = {1'b0, ac_q}
                                + (DATA_W+1)'(1);
            default: ;
          endcase
        end
        S_EX1: begin
          unique case (ir_q)
            OP_LDA: ac_d = mbr_q;
            OP_ADD: {e_d, ac_d} = {1'b0, ac_q}
                                + {1'b0, mbr_q};
            OP_AND: ac_d = ac_q & mbr_q;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
